pixel_block_feeder: RTL and testbench

Upstream feeder for the 8-lane pixel accumulator (`pixel_parallel_sum`).
- Accepts a valid/ready stream of 8-bit pixels and packs eight pixels into each 64-bit word.
- Drives the accumulator's `in_data`/`CE`/`LOAD`/`ADDSUB`/`RST` controls, clearing it at the start of every block.
- Flags when the accumulator's 25-bit `total_sum_out` holds a completed block sum, together with the number of pixels that sum covers, so a downstream stage can normalise it.

---
 rtl/pixel_block_feeder.sv | 96 +++++++++
 tb/tb_pixel_block_feeder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_feeder.sv
// Packs an 8-bit pixel stream into 64-bit words and sequences the clear,
// accumulate and result-valid controls of the 8-lane pixel accumulator.
module pixel_block_feeder #(
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic [63:0] in_data,
  output logic        CE,
  output logic        LOAD,
  output logic        ADDSUB,
  output logic        RST,
  output logic        sum_valid,
  output logic [15:0] pixel_count
);

  typedef enum logic [1:0] {CLEAR, FILL, FLUSH, DONE} state_t;

  localparam logic [12:0] LAST_WORD = 13'(WORDS_PER_BLOCK - 1);

  state_t      state, state_nxt;
  logic [2:0]  byte_idx;
  logic [12:0] word_cnt;
  logic [15:0] pix_cnt;
  logic [63:0] part_word;
  logic [63:0] cur_word;
  logic        hs;
  logic        word_done;
  logic        block_end;

  assign ADDSUB = 1'b1;
  assign RST    = ~RST_N;

  always_comb begin
    hs        = pix_valid && pix_ready;
    cur_word  = part_word;
    cur_word[{byte_idx, 3'b000} +: 8] = pix_in;
    word_done = hs && ((byte_idx == 3'd7) || pix_last);
    block_end = word_done && (pix_last || (word_cnt == LAST_WORD));
    state_nxt = state;
    case (state)
      CLEAR:   state_nxt = FILL;
      FILL:    if (block_end) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Control outputs are registered: the clear issued in CLEAR and each word
  // completed in FILL reach the accumulator during the following cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= CLEAR;
      pix_ready   <= 1'b0;
      in_data     <= '0;
      CE          <= 1'b0;
      LOAD        <= 1'b0;
      sum_valid   <= 1'b0;
      pixel_count <= '0;
      byte_idx    <= '0;
      word_cnt    <= '0;
      pix_cnt     <= '0;
      part_word   <= '0;
    end else begin
      state     <= state_nxt;
      pix_ready <= (state_nxt == FILL);
      LOAD      <= (state == CLEAR);
      CE        <= (state == CLEAR) || word_done;
      in_data   <= word_done ? cur_word : '0;
      sum_valid <= (state == FLUSH);
      if (state == FLUSH) pixel_count <= pix_cnt;
      if (state == DONE) begin
        byte_idx  <= '0;
        word_cnt  <= '0;
        pix_cnt   <= '0;
        part_word <= '0;
      end else if (hs) begin
        pix_cnt <= pix_cnt + 16'd1;
        if (word_done) begin
          part_word <= '0;
          byte_idx  <= '0;
          word_cnt  <= word_cnt + 13'd1;
        end else begin
          part_word <= cur_word;
          byte_idx  <= byte_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_block_feeder.sv
// Bench for pixel_block_feeder: one 2-word-block and one 8-word-block
// instance, an accumulator model, and a stream-level packing reference.
module tb_pixel_block_feeder;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } tx_t;

  logic        CLK = 1'b0;
  logic        rst_n2 = 1'b0;
  logic        rst_n8 = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        use8 = 1'b1;

  logic        pix_ready_2, ce_2, load_2, addsub_2, rst_2, sv_2;
  logic [63:0] in_data_2;
  logic [15:0] pcnt_2;
  logic        pix_ready_8, ce_8, load_8, addsub_8, rst_8, sv_8;
  logic [63:0] in_data_8;
  logic [15:0] pcnt_8;

  pixel_block_feeder #(.WORDS_PER_BLOCK(2)) dut2 (
    .CLK(CLK), .RST_N(rst_n2), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready_2), .in_data(in_data_2),
    .CE(ce_2), .LOAD(load_2), .ADDSUB(addsub_2), .RST(rst_2),
    .sum_valid(sv_2), .pixel_count(pcnt_2)
  );

  pixel_block_feeder #(.WORDS_PER_BLOCK(8)) dut8 (
    .CLK(CLK), .RST_N(rst_n8), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready_8), .in_data(in_data_8),
    .CE(ce_8), .LOAD(load_8), .ADDSUB(addsub_8), .RST(rst_8),
    .sum_valid(sv_8), .pixel_count(pcnt_8)
  );

  always #5 CLK = ~CLK;

  logic        rdy, ce, load, addsub, rst_o, sv, rst_act_n;
  logic [63:0] in_d;
  logic [15:0] pcnt;
  assign rdy       = use8 ? pix_ready_8 : pix_ready_2;
  assign ce        = use8 ? ce_8 : ce_2;
  assign load      = use8 ? load_8 : load_2;
  assign addsub    = use8 ? addsub_8 : addsub_2;
  assign rst_o     = use8 ? rst_8 : rst_2;
  assign sv        = use8 ? sv_8 : sv_2;
  assign in_d      = use8 ? in_data_8 : in_data_2;
  assign pcnt      = use8 ? pcnt_8 : pcnt_2;
  assign rst_act_n = use8 ? rst_n8 : rst_n2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tx_t         tx[$];
  logic [63:0] words[$], exp_words[$];
  logic [24:0] sums[$], exp_sums[$];
  logic [15:0] counts[$], exp_counts[$];
  int          sv_cycs[$];
  int          rst_cyc = 0, last_hs_cyc = 0;
  int          load_cnt = 0, bad_load = 0, empty_ce = 0, ready_viol = 0, hold_viol = 0;
  logic        prev_sv = 1'b0, prev_rdy = 1'b0;
  logic [15:0] held = '0;
  logic [24:0] acc = '0;

  function automatic logic [24:0] bsum(input logic [63:0] w);
    logic [24:0] s = '0;
    for (int i = 0; i < 8; i++) s += 25'(w[8*i +: 8]);
    return s;
  endfunction

  // Accumulator: LOAD reloads with in_data (always zero here), CE adds lanes.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rst_o) acc <= '0;
    else if (ce) acc <= load ? bsum(in_d) : acc + bsum(in_d);
  end

  always @(negedge CLK) begin
    if (!rst_act_n) rst_cyc = cyc;
    if (ce && !load) begin
      words.push_back(in_d);
      if (in_d == '0) empty_ce++;
    end
    if (load) begin
      load_cnt++;
      if (!ce || in_d != '0) bad_load++;
    end
    if (pix_valid && rdy && pix_last) last_hs_cyc = cyc;
    if (sv) begin
      sums.push_back(acc);
      counts.push_back(pcnt);
      sv_cycs.push_back(cyc);
      if (rdy || prev_rdy) ready_viol++;
    end
    if (prev_sv && rdy) ready_viol++;
    if (sv) held = pcnt;
    else if (pcnt !== held) hold_viol++;
    if (rst_o) held = '0;
    prev_sv  = sv;
    prev_rdy = rdy;
  end

  task automatic clear_rec();
    words.delete(); exp_words.delete(); sums.delete(); exp_sums.delete();
    counts.delete(); exp_counts.delete(); sv_cycs.delete();
    load_cnt = 0; bad_load = 0; empty_ce = 0; ready_viol = 0; hold_viol = 0;
    held = pcnt;
  endtask

  // Reference: bytes of one block packed little-endian, eight per word.
  task automatic expect_block(input logic [7:0] b[$], input bit has_last);
    logic [63:0] w;
    logic [24:0] s = '0;
    int unsigned n = b.size();
    for (int unsigned i = 0; i < n; i++) begin
      s += 25'(b[i]);
      tx.push_back(tx_t'{d: b[i], l: has_last && (i == n - 1)});
    end
    for (int unsigned base = 0; base < n; base += 8) begin
      w = '0;
      for (int unsigned j = 0; j < 8; j++)
        if (base + j < n) w |= 64'(b[base + j]) << (8 * j);
      exp_words.push_back(w);
    end
    exp_sums.push_back(s);
    exp_counts.push_back(16'(n));
  endtask

  task automatic send_all(input int unsigned pct);
    int unsigned budget = 0;
    bit hs;
    while (tx.size() > 0 && budget < 5000) begin
      pix_valid = ($urandom_range(99, 0) < pct);
      pix_in    = tx[0].d;
      pix_last  = tx[0].l;
      @(negedge CLK);
      hs = pix_valid && rdy;
      @(posedge CLK);
      #1;
      if (hs) void'(tx.pop_front());
      budget++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    if (tx.size() > 0) begin
      checks++; errors++;
      $display("FAIL send_timeout got %0d bytes left want 0", tx.size());
      tx.delete();
    end
  endtask

  task automatic wait_sv(input int n);
    int unsigned b = 0;
    while (sums.size() < n && b < 3000) begin
      @(negedge CLK); #1;
      b++;
    end
    if (sums.size() < n) begin
      checks++; errors++;
      $display("FAIL sv_timeout got %0d sums want %0d", sums.size(), n);
    end
    @(posedge CLK); #1;
  endtask

  task automatic reset_hold(input bit sel8);
    rst_n2 = 1'b0; rst_n8 = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
    use8 = sel8;
    tx.delete();
    repeat (2) @(posedge CLK);
    #1;
    clear_rec();
  endtask

  task automatic release_rst();
    if (use8) rst_n8 = 1'b1; else rst_n2 = 1'b1;
  endtask

  task automatic test_reset();
    reset_hold(1'b1);
    checks += 8;
    if (in_d !== 64'h0) begin errors++; $display("FAIL rst_in_data got %h want 0", in_d); end
    if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b want 0", ce); end
    if (load !== 1'b0) begin errors++; $display("FAIL rst_load got %b want 0", load); end
    if (sv !== 1'b0) begin errors++; $display("FAIL rst_sum_valid got %b want 0", sv); end
    if (rdy !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %b want 0", rdy); end
    if (pcnt !== 16'h0) begin errors++; $display("FAIL rst_pixel_count got %0d want 0", pcnt); end
    if (addsub !== 1'b1) begin errors++; $display("FAIL rst_addsub got %b want 1", addsub); end
    if (rst_o !== 1'b1) begin errors++; $display("FAIL rst_RST got %b want 1", rst_o); end
    release_rst();
    #1;
    checks++;
    if (rst_o !== 1'b0) begin errors++; $display("FAIL rst_RST_release got %b want 0", rst_o); end
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    reset_hold(1'b0);
    for (int i = 1; i <= 16; i++) b.push_back(8'(i));
    expect_block(b, 1'b0);
    release_rst();
    send_all(100);
    wait_sv(1);
    checks += 6;
    if (words.size() != 2) begin errors++; $display("FAIL basic_words got %0d want 2", words.size()); end
    else begin
      if (words[0] !== exp_words[0]) begin errors++; $display("FAIL basic_word0 got %h want %h", words[0], exp_words[0]); end
      if (words[1] !== exp_words[1]) begin errors++; $display("FAIL basic_word1 got %h want %h", words[1], exp_words[1]); end
    end
    if (sums.size() > 0) begin
      if (sums[0] !== exp_sums[0]) begin errors++; $display("FAIL basic_sum got %0d want %0d", sums[0], exp_sums[0]); end
      if (counts[0] !== exp_counts[0]) begin errors++; $display("FAIL basic_count got %0d want %0d", counts[0], exp_counts[0]); end
      if (sv_cycs[0] - rst_cyc != 19) begin errors++; $display("FAIL basic_cycles got %0d want 19", sv_cycs[0] - rst_cyc); end
    end
    checks += 2;
    if (load_cnt != 1) begin errors++; $display("FAIL basic_load_pulses got %0d want 1", load_cnt); end
    if (bad_load != 0) begin errors++; $display("FAIL basic_load_form got %0d want 0", bad_load); end
  endtask

  task automatic test_early_last();
    logic [7:0] b[$];
    reset_hold(1'b1);
    repeat (11) b.push_back(8'hFF);
    expect_block(b, 1'b1);
    release_rst();
    send_all(100);
    wait_sv(1);
    checks += 3;
    if (words.size() != 2) begin errors++; $display("FAIL early_words got %0d want 2", words.size()); end
    else if (words[1] !== 64'h0000000000FFFFFF) begin errors++; $display("FAIL early_word1 got %h want 0000000000ffffff", words[1]); end
    if (sums.size() > 0) begin
      if (sums[0] !== 25'd2805) begin errors++; $display("FAIL early_sum got %0d want 2805", sums[0]); end
      if (counts[0] !== 16'd11) begin errors++; $display("FAIL early_count got %0d want 11", counts[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    clear_rec();
    repeat (64) b.push_back(8'd2);
    expect_block(b, 1'b0);
    send_all(50);
    wait_sv(1);
    checks += 6;
    if (words.size() != exp_words.size()) begin errors++; $display("FAIL bp_words got %0d want %0d", words.size(), exp_words.size()); end
    else foreach (words[i]) if (words[i] !== exp_words[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, words[i], exp_words[i]); end
    if (sums.size() > 0) begin
      if (sums[0] !== exp_sums[0]) begin errors++; $display("FAIL bp_sum got %0d want %0d", sums[0], exp_sums[0]); end
      if (counts[0] !== exp_counts[0]) begin errors++; $display("FAIL bp_count got %0d want %0d", counts[0], exp_counts[0]); end
    end
    if (empty_ce != 0) begin errors++; $display("FAIL bp_empty_ce got %0d want 0", empty_ce); end
    if (ready_viol != 0) begin errors++; $display("FAIL bp_ready_idle got %0d want 0", ready_viol); end
    if (hold_viol != 0) begin errors++; $display("FAIL bp_count_hold got %0d want 0", hold_viol); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1[$], b3[$];
    clear_rec();
    repeat (64) b1.push_back(8'd1);
    repeat (64) b3.push_back(8'd3);
    expect_block(b1, 1'b0);
    expect_block(b3, 1'b0);
    send_all(100);
    wait_sv(2);
    checks += 3;
    if (sums.size() != 2) begin errors++; $display("FAIL b2b_nsums got %0d want 2", sums.size()); end
    else begin
      if (sums[0] !== 25'd64) begin errors++; $display("FAIL b2b_sum0 got %0d want 64", sums[0]); end
      if (sums[1] !== 25'd192) begin errors++; $display("FAIL b2b_sum1 got %0d want 192", sums[1]); end
      checks++;
      if (sv_cycs[1] - sv_cycs[0] != 67) begin errors++; $display("FAIL b2b_period got %0d want 67", sv_cycs[1] - sv_cycs[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    clear_rec();
    repeat (20) tx.push_back(tx_t'{d: 8'd1, l: 1'b0});
    send_all(100);
    rst_n8 = 1'b0;
    #1;
    checks++;
    if (rst_o !== 1'b1) begin errors++; $display("FAIL mid_RST got %b want 1", rst_o); end
    @(posedge CLK); #1;
    rst_n8 = 1'b1;
    checks += 6;
    if (in_d !== 64'h0) begin errors++; $display("FAIL mid_in_data got %h want 0", in_d); end
    if (ce !== 1'b0) begin errors++; $display("FAIL mid_ce got %b want 0", ce); end
    if (load !== 1'b0) begin errors++; $display("FAIL mid_load got %b want 0", load); end
    if (sv !== 1'b0) begin errors++; $display("FAIL mid_sum_valid got %b want 0", sv); end
    if (rdy !== 1'b0) begin errors++; $display("FAIL mid_pix_ready got %b want 0", rdy); end
    if (pcnt !== 16'h0) begin errors++; $display("FAIL mid_pixel_count got %0d want 0", pcnt); end
    repeat (64) b.push_back(8'd1);
    expect_block(b, 1'b0);
    send_all(100);
    wait_sv(1);
    repeat (4) @(posedge CLK);
    #1;
    checks += 2;
    if (sums.size() != 1) begin errors++; $display("FAIL mid_nsums got %0d want 1", sums.size()); end
    else if (sums[0] !== 25'd64) begin errors++; $display("FAIL mid_sum got %0d want 64", sums[0]); end
    if (hold_viol != 0) begin errors++; $display("FAIL mid_count_hold got %0d want 0", hold_viol); end
  endtask

  task automatic test_single();
    logic [7:0] b[$];
    clear_rec();
    b.push_back(8'h80);
    expect_block(b, 1'b1);
    send_all(100);
    wait_sv(1);
    checks += 2;
    if (words.size() != 1) begin errors++; $display("FAIL single_words got %0d want 1", words.size()); end
    else if (words[0] !== 64'h80) begin errors++; $display("FAIL single_word got %h want 80", words[0]); end
    if (sums.size() > 0) begin
      checks += 3;
      if (sums[0] !== 25'd128) begin errors++; $display("FAIL single_sum got %0d want 128", sums[0]); end
      if (counts[0] !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", counts[0]); end
      if (sv_cycs[0] - last_hs_cyc != 2) begin errors++; $display("FAIL single_latency got %0d want 2", sv_cycs[0] - last_hs_cyc); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int unsigned len;
    bit last;
    clear_rec();
    for (int unsigned k = 0; k < 6; k++) begin
      len = $urandom_range(64, 1);
      b.delete();
      for (int unsigned i = 0; i < len; i++) b.push_back(8'($urandom_range(255, 1)));
      last = (len < 64) ? 1'b1 : 1'($urandom_range(1, 0));
      expect_block(b, last);
    end
    send_all($urandom_range(100, 30));
    wait_sv(6);
    checks += 6;
    if (words.size() != exp_words.size()) begin errors++; $display("FAIL rnd_words got %0d want %0d", words.size(), exp_words.size()); end
    else foreach (words[i]) if (words[i] !== exp_words[i]) begin errors++; $display("FAIL rnd_word%0d got %h want %h", i, words[i], exp_words[i]); end
    if (sums.size() != exp_sums.size()) begin errors++; $display("FAIL rnd_nsums got %0d want %0d", sums.size(), exp_sums.size()); end
    else foreach (sums[i]) begin
      if (sums[i] !== exp_sums[i]) begin errors++; $display("FAIL rnd_sum%0d got %0d want %0d", i, sums[i], exp_sums[i]); end
      if (counts[i] !== exp_counts[i]) begin errors++; $display("FAIL rnd_count%0d got %0d want %0d", i, counts[i], exp_counts[i]); end
    end
    if (ready_viol != 0) begin errors++; $display("FAIL rnd_ready_idle got %0d want 0", ready_viol); end
    if (empty_ce != 0) begin errors++; $display("FAIL rnd_empty_ce got %0d want 0", empty_ce); end
    if (hold_viol != 0) begin errors++; $display("FAIL rnd_count_hold got %0d want 0", hold_viol); end
    if (bad_load != 0) begin errors++; $display("FAIL rnd_load_form got %0d want 0", bad_load); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
